// File: rtl/block_pixel_loader.sv
// block_pixel_loader: fetches a BLK x BLK grid of subsampled frame pixels
// starting at a block origin. Memory reads are pipelined with a fixed
// latency. Samples that fall outside the frame are replaced with FILL. The
// finished block is published as one packed vector together with a single
// done pulse.
//
// Handshake: start is a request that is taken only while busy is low. A start
// seen while busy is high is dropped, not queued. done is a one-cycle strobe.
// block_pixels is valid from the done cycle until the next done.
module block_pixel_loader #(
    parameter int PIX_W   = 9,
    parameter int BLK     = 4,
    parameter int STEP_SH = 1,
    parameter int ORG_SH  = 3,
    parameter int COORD_W = 8,
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480,
    parameter int FILL    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [COORD_W-1:0]         block_x,
    input  logic [COORD_W-1:0]         block_y,
    input  logic [PIX_W-1:0]           memory_in,
    output logic [ADDR_W-1:0]          mem_hcount,
    output logic [ADDR_W-1:0]          mem_vcount,
    output logic                       busy,
    output logic                       done,
    output logic [BLK*BLK*PIX_W-1:0]   block_pixels
);
    localparam int N  = BLK * BLK;
    localparam int FW = COORD_W + ORG_SH + 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int DW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [PIX_W-1:0] FILL_PIX = PIX_W'(FILL);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state;
    logic [COORD_W-1:0] bx_q, by_q;
    logic [KW-1:0]      k_q;
    logic [CW-1:0]      col_q, row_q;
    logic [DW-1:0]      drain_q;
    logic               clip_q;

    // Tag pipeline. Each stage carries {valid, clip, k} and lines up with the
    // data returning from memory.
    logic [MEM_LAT-1:0]         tag_v;
    logic [MEM_LAT-1:0]         tag_c;
    logic [MEM_LAT-1:0][KW-1:0] tag_k;

    logic [N*PIX_W-1:0] shadow, shadow_next;

    logic [COORD_W-1:0] src_bx, src_by;
    logic [CW-1:0]      src_col, src_row;
    logic [FW-1:0]      h_full, v_full;
    logic               clip_next;

    // Address and clip for the sample that is loaded into mem_*count at the next edge.
    always_comb begin
        src_bx  = bx_q;
        src_by  = by_q;
        src_col = col_q;
        src_row = row_q;
        if (state == IDLE) begin
            src_bx  = block_x;
            src_by  = block_y;
            src_col = '0;
            src_row = '0;
        end else if (col_q == CW'(BLK - 1)) begin
            src_col = '0;
            src_row = row_q + 1'b1;
        end else begin
            src_col = col_q + 1'b1;
        end
        h_full    = (FW'(src_bx) << ORG_SH) + (FW'(src_col) << STEP_SH);
        v_full    = (FW'(src_by) << ORG_SH) + (FW'(src_row) << STEP_SH);
        clip_next = (h_full >= FW'(FRAME_W)) || (v_full >= FW'(FRAME_H));
    end

    // Control FSM: accept, issue N addresses, drain the read pipeline, then publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_hcount   <= '0;
            mem_vcount   <= '0;
            block_pixels <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            k_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            drain_q      <= '0;
            clip_q       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bx_q       <= block_x;
                        by_q       <= block_y;
                        k_q        <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                        drain_q    <= '0;
                        mem_hcount <= h_full[ADDR_W-1:0];
                        mem_vcount <= v_full[ADDR_W-1:0];
                        clip_q     <= clip_next;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (k_q == KW'(N - 1)) begin
                        drain_q <= '0;
                        state   <= DRAIN;
                    end else begin
                        k_q        <= k_q + 1'b1;
                        col_q      <= src_col;
                        row_q      <= src_row;
                        mem_hcount <= h_full[ADDR_W-1:0];
                        mem_vcount <= v_full[ADDR_W-1:0];
                        clip_q     <= clip_next;
                    end
                end
                DRAIN: begin
                    if (drain_q == DW'(MEM_LAT - 1)) begin
                        // The last sample lands at this same edge, so publish the merged view.
                        block_pixels <= shadow_next;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift issued-sample tags alongside the memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_c <= '0;
            tag_k <= '0;
        end else begin
            tag_v[0] <= (state == ISSUE);
            tag_c[0] <= clip_q;
            tag_k[0] <= k_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_c[i] <= tag_c[i-1];
                tag_k[i] <= tag_k[i-1];
            end
        end
    end

    // Shadow buffer with the returning sample merged into its slot.
    always_comb begin
        shadow_next = shadow;
        if (tag_v[MEM_LAT-1])
            shadow_next[tag_k[MEM_LAT-1]*PIX_W +: PIX_W] =
                tag_c[MEM_LAT-1] ? FILL_PIX : memory_in;
    end

    // Register the shadow buffer.
    always_ff @(posedge clk) begin
        if (reset) shadow <= '0;
        else       shadow <= shadow_next;
    end
endmodule

// File: doc/block_pixel_loader.md
# block_pixel_loader

Parametrised block fetcher that sits between the frame-memory read port and the per-block processing logic. On `start`, it reads a BLK×BLK grid of subsampled pixels whose origin is set by block coordinates. It handles a configurable memory read latency, replaces out-of-frame samples with a fill value, and presents the whole block as one packed, double-buffered vector with a one-cycle `done` pulse.

## Interface
- PIX_W, 9: pixel width in bits.
- BLK, 4: pixels per block side; N = BLK*BLK samples per load.
- STEP_SH, 1: sample spacing is 1<<STEP_SH frame pixels.
- ORG_SH, 3: block origin spacing is 1<<ORG_SH frame pixels.
- COORD_W, 8: width of block_x / block_y.
- ADDR_W, 10: width of mem_hcount / mem_vcount.
- MEM_LAT, 2: cycles from address out to data valid on memory_in (≥1).
- FRAME_W, 640 and FRAME_H, 480: frame bounds used for clipping.
- FILL, 0: value captured for clipped samples.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request a load; accepted only when busy=0.
- block_x  in  COORD_W  block column, latched at accept.
- block_y  in  COORD_W  block row, latched at accept.
- memory_in  in  PIX_W  frame-memory read data.
- mem_hcount  out  ADDR_W  read address x (registered).
- mem_vcount  out  ADDR_W  read address y (registered).
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse; block_pixels updated.
- block_pixels  out  BLK*BLK*PIX_W  sample k = row*BLK+col at bits [k*PIX_W +: PIX_W].

## Operation
- States: IDLE → ISSUE → DRAIN → IDLE.
- IDLE:
  - When start=1, latch block_x/block_y, clear the counters and go to ISSUE.
- ISSUE:
  - Spans N cycles, issuing sample k = 0..N-1 in raster order (col fastest).
  - h = (bx<<ORG_SH) + (col<<STEP_SH) and v = (by<<ORG_SH) + (row<<STEP_SH), computed at full width (COORD_W+ORG_SH+1).
  - mem_hcount / mem_vcount carry the low ADDR_W bits.
  - clip = (h ≥ FRAME_W) | (v ≥ FRAME_H), computed on the full-width values.
  - After sample N-1, go to DRAIN.
- Tag pipeline: MEM_LAT stages carrying {valid, clip, k}. A valid tag emerging writes the shadow slot k with memory_in, or with FILL if clip=1.
- DRAIN:
  - Lasts MEM_LAT cycles, until the last tag has emerged.
  - Then copy shadow → block_pixels, pulse done, and return to IDLE.
- block_pixels changes only on the done cycle. It holds the previous block for the whole of any later load.
- start while busy=1 is ignored and has no queued effect.
- start in the done cycle (busy=0) is accepted, giving back-to-back loads.
- reset, at any time including mid-load:
  - state returns to IDLE.
  - busy, done, mem_hcount, mem_vcount, block_pixels, the shadow buffer, the counters and all tag valids go to 0.
  - No done pulse is produced for the aborted load.

## Timing
- start sampled at edge S.
- Sample k address is on mem_*count during cycle S+1+k.
- Its data is captured at edge S+1+k+MEM_LAT.
- busy is high for cycles S+1 .. S+N+MEM_LAT.
- done is high for exactly cycle S+N+MEM_LAT+1, with block_pixels valid from that cycle. Load latency is N+MEM_LAT+1 (19 with defaults).
- mem_*count hold their last value outside ISSUE.
- Reset values: busy=0, done=0, mem_hcount=0, mem_vcount=0, block_pixels=0.

## Test plan
- Defaults, block_x=1, block_y=2. Memory model returns (h+v) & 0x1FF with 2-cycle latency.
  - Addresses must run h=8,10,12,14 for each v=16,18,20,22.
  - pixel0=24, pixel15=36.
  - done at S+19, one cycle wide.
- Clipping, block_x=80, block_y=0:
  - All h ≥ 640, so all 16 samples = FILL=0.
  - block_x=79 gives no clipping: h=632..638.
- Back-to-back: second start in the done cycle is accepted.
  - Its done arrives 19 cycles later.
  - block_pixels holds the first block until then.
- start asserted repeatedly while busy:
  - Ignored; exactly one done.
  - Coordinate change mid-load does not alter the addresses.
- reset asserted at S+7:
  - All outputs are 0 the next cycle and no done appears.
  - A new start then loads correctly.
- MEM_LAT=4 and BLK=2 build: done at S+4+4+1=S+9 with correct data ordering.
